aibcr3aux_osc_cntr_gen2: RTL and testbench

AIBCR3AUX_OSC_CNTR_GEN2 -- requirements
Module: aibcr3aux_osc_cntr_gen2

---
 rtl/aibcr3aux_osc_cntr_gen2.sv | 161 ++++++++++++++++
 tb/tb_aibcr3aux_osc_cntr_gen2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3aux_osc_cntr_gen2.sv
// aibcr3aux_osc_cntr_gen2 -- oscillator frequency counter.
// Counts prescaled ticks of its own clock between a start and a stop request
// and captures the result in out_bin. A sticky ovf flag marks a measurement
// whose count passed all-ones.
// Build option: define AIBCR3AUX_OSC_CNTR_SAT_EN to make the running count
// saturate at all-ones on overflow; by default it wraps to zero.
module aibcr3aux_osc_cntr_gen2 #(
  parameter int WIDTH = 6,   // count width, 4..16
  parameter int PRE_W = 3    // prescale-select width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PRE_W-1:0] cntr,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] cnt_live,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // Wide enough to reach 2^(2^PRE_W-1)-1, the largest terminal count.
  localparam int PS_W = (1 << PRE_W) + 1;
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_acc;
  logic             w_stop_acc;
  logic             w_counting;

  logic [PRE_W-1:0] r_cntr_lat;
  logic [PS_W-1:0]  r_ps;
  logic [PS_W-1:0]  w_ps_term;
  logic             w_tick;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_ovf_evt;
  logic             r_ovf;
  logic [WIDTH-1:0] r_out_bin;

  // State register; reset abandons any measurement in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus start/stop acceptance. In COUNT stop has priority and
  // start is ignored; in IDLE/DONE start has priority and stop is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_stop_acc  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_COUNT;
          w_start_acc = 1'b1;
        end
      end
      S_COUNT: begin
        if (stop) begin
          w_state_nxt = S_DONE;
          w_stop_acc  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_counting = (r_state == S_COUNT) && en;

  // Terminal prescaler value 2^cntr_lat-1; zero select ticks every enabled cycle.
  always_comb begin
    w_ps_term = (PS_ONE << r_cntr_lat) - PS_ONE;
    w_tick    = w_counting && (r_ps == w_ps_term);
  end

  // Next running count including this cycle's tick and the overflow rule.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_evt = 1'b0;
    if (w_tick) begin
      if (&r_cnt) begin
        w_ovf_evt = 1'b1;
`ifdef AIBCR3AUX_OSC_CNTR_SAT_EN
        w_cnt_nxt = r_cnt;
`else
        w_cnt_nxt = '0;
`endif
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end
  end

  // Prescale select is sampled only when a measurement starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cntr_lat <= '0;
    end else if (w_start_acc) begin
      r_cntr_lat <= cntr;
    end
  end

  // Prescaler: cleared on start, advances on enabled COUNT cycles, wraps on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps <= '0;
    end else if (w_start_acc) begin
      r_ps <= '0;
    end else if (w_counting) begin
      r_ps <= w_tick ? '0 : (r_ps + PS_ONE);
    end
  end

  // Running count and sticky overflow, both cleared on start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_acc) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Capture on stop, including a tick that lands in the stop cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_bin <= '0;
    end else if (w_stop_acc) begin
      r_out_bin <= w_cnt_nxt;
    end
  end

  assign out_bin  = r_out_bin;
  assign cnt_live = r_cnt;
  assign ovf      = r_ovf;
  assign busy     = (r_state == S_COUNT);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_aibcr3aux_osc_cntr_gen2.sv
// Bench for aibcr3aux_osc_cntr_gen2 (WIDTH=6, PRE_W=3). Each measurement pushes
// its hand-computed result into a queue; a monitor pops it when done rises.
module tb_aibcr3aux_osc_cntr_gen2;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] cntr;
  logic       start;
  logic       stop;
  logic [5:0] out_bin;
  logic [5:0] cnt_live;
  logic       busy;
  logic       done;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0] o;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] last_out;
  logic       done_q;

`ifdef AIBCR3AUX_OSC_CNTR_SAT_EN
  localparam logic [5:0] EXP70 = 6'd63;
  localparam logic [5:0] EXP64 = 6'd63;
`else
  localparam logic [5:0] EXP70 = 6'd6;
  localparam logic [5:0] EXP64 = 6'd0;
`endif

  aibcr3aux_osc_cntr_gen2 #(.WIDTH(6), .PRE_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cntr     (cntr),
    .start    (start),
    .stop     (stop),
    .out_bin  (out_bin),
    .cnt_live (cnt_live),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, compare against the oldest expectation.
  initial begin
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: done rose with out_bin=%0d and no expectation queued", out_bin);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_out_bin",  32'(out_bin),  32'(e.o));
          chk("sb_cnt_live", 32'(cnt_live), 32'(e.o));
          chk("sb_ovf",      32'(ovf),      32'(e.v));
          chk("sb_busy",     32'(busy),     32'd0);
        end
      end
      done_q = done;
    end
  end

  // One measurement: start, n COUNT cycles with stop in the last one.
  task automatic run_meas(input logic [2:0] c, input int n, input logic [127:0] off,
                          input bit chg, input logic [2:0] c2,
                          input bit both_end, input bit both_start,
                          input logic [5:0] exp_o, input logic exp_v);
    cntr  = c;
    start = 1'b1;
    stop  = both_start;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_busy",     32'(busy),     32'd1);
    chk("start_done",     32'(done),     32'd0);
    chk("start_ovf",      32'(ovf),      32'd0);
    chk("start_cnt_live", 32'(cnt_live), 32'd0);
    chk("start_out_held", 32'(out_bin),  32'(last_out));
    for (int k = 1; k <= n; k++) begin
      en = ~off[k-1];
      if (chg && k == 7) cntr = c2;
      stop  = (k == n);
      start = both_end && (k == n);
      if (k == n) sb.push_back('{o: exp_o, v: exp_v});
      @(posedge clk); #1;
    end
    stop     = 1'b0;
    start    = 1'b0;
    en       = 1'b1;
    last_out = exp_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    cntr     = '0;
    start    = 1'b0;
    stop     = 1'b0;
    last_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_bin",  32'(out_bin),  32'd0);
    chk("rst_cnt_live", 32'(cnt_live), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ovf",      32'(ovf),      32'd0);
    reset = 1'b0;

    // First start right after reset release; cntr=0, stop in 10th cycle.
    run_meas(3'd0, 10, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd10, 1'b0);

    // Stop while DONE is ignored.
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("done_stop_ign_done", 32'(done),    32'd1);
    chk("done_stop_ign_out",  32'(out_bin), 32'd10);

    // Divide by 4 for 20 cycles, select changed to 0 mid-count.
    run_meas(3'd2, 20, 128'd0, 1'b1, 3'd0, 1'b0, 1'b0, 6'd5, 1'b0);
    // Divide by 2 for 7 cycles, divide by 8 for 17 cycles.
    run_meas(3'd1, 7,  128'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd3, 1'b0);
    run_meas(3'd3, 17, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0);

    // Overflow: 70 ticks, then exactly 64 ticks (overflow in the stop cycle).
    run_meas(3'd0, 70, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, EXP70, 1'b1);
    run_meas(3'd0, 64, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, EXP64, 1'b1);

    // en low in cycles 3,4,5,11,12 of 20.
    run_meas(3'd0, 20, 128'h0C1C, 1'b0, 3'd0, 1'b0, 1'b0, 6'd15, 1'b0);

    // start+stop together in COUNT: stop wins.
    run_meas(3'd0, 5, 128'd0, 1'b0, 3'd0, 1'b1, 1'b0, 6'd5, 1'b0);
    @(posedge clk); #1;
    chk("both_count_done", 32'(done), 32'd1);
    chk("both_count_busy", 32'(busy), 32'd0);

    // start+stop together in DONE: start wins.
    run_meas(3'd0, 4, 128'd0, 1'b0, 3'd0, 1'b0, 1'b1, 6'd4, 1'b0);

    // Reset during COUNT cycle 8.
    cntr  = 3'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_cnt_live", 32'(cnt_live), 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_done",     32'(done),     32'd0);
    chk("mid_rst_out_bin",  32'(out_bin),  32'd0);
    chk("mid_rst_cnt_live", 32'(cnt_live), 32'd0);
    chk("mid_rst_ovf",      32'(ovf),      32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    last_out = '0;

    // Stop in IDLE is ignored.
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("idle_stop_done", 32'(done), 32'd0);
    chk("idle_stop_busy", 32'(busy), 32'd0);

    run_meas(3'd0, 3, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd3, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
